iiitb_pusr: RTL and testbench
=============================

Name: iiitb_pusr

Overview:
Parametrised universal shift register, successor to the fixed 8-bit USR. Adds WIDTH generalisation, multi-position shifts, rotate and arithmetic modes, a clock enable, synchronous clear, and a burst engine that repeats a shift/rotate for N cycles with busy/done status. Used as a serialiser/deserialiser and barrel-style datapath element. Cascadable via the serial outputs.

Parameters:
WIDTH, 8, register width in bits (>=2)
SH_W, $clog2(WIDTH), shift-amount width (derived localparam)
CNT_W, $clog2(WIDTH+1), burst-length width (derived localparam)

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous clear; highest synchronous priority
en  in  1  clock enable for direct ops and burst progress
mode  in  3  operation select (encoding below)
shamt  in  SH_W  positions per operation, 0..WIDTH-1
sl_ser  in  1  fill bit entering LSB side on shift-left
sr_ser  in  1  fill bit entering MSB side on shift-right
data_in  in  WIDTH  parallel load value
start  in  1  request a burst of the current mode
burst_len  in  CNT_W  number of burst operations, 1..WIDTH
data_out  out  WIDTH  register contents
sl_out  out  1  data_out[WIDTH-1], for cascading
sr_out  out  1  data_out[0], for cascading
busy  out  1  burst in progress
done  out  1  one-cycle burst-complete pulse

Behaviour:
- clear_n=0: data_out=0, busy=0, done=0, FSM=IDLE, burst counter=0, immediately and regardless of clock.
- mode: 000 SHL, 001 SHR, 010 LOAD, 011 HOLD, 100 ROTL, 101 ROTR, 110 ASR (MSB replicated), 111 reserved = HOLD. Low codes match the legacy select encoding.
- SHL by k: vacated k LSBs = sl_ser. SHR by k: vacated k MSBs = sr_ser. shamt=0 leaves the value unchanged for every shift/rotate mode. shamt is compared modulo nothing; values >=WIDTH cannot occur for power-of-2 WIDTH. For other WIDTH, shamt>=WIDTH behaves as HOLD.
- Synchronous priority per edge: sync_clr (data_out=0, FSM->IDLE, busy=0, no done) > burst RUN step > direct mode op when en=1 > hold.
- Latency: one edge. data_out reflects the op after the sampling edge. sl_out/sr_out are combinational from data_out.
- FSM IDLE:
  - start=1 with en=1, burst_len!=0, and mode in {SHL,SHR,ROTL,ROTR,ASR} accepts the burst: latch mode, shamt, sl_ser, sr_ser, and burst_len. The accepting edge performs op 1.
  - If burst_len=1: stay IDLE and done=1 next cycle.
  - Otherwise go to RUN, busy=1, counter=burst_len-1.
  - start with an invalid mode or burst_len=0 is ignored and executes as a normal direct op.
- FSM RUN:
  - Each edge with en=1 performs the latched op and decrements counter. en=0 stalls (no op, counter held).
  - The edge on which counter reaches 0 performs the last op, returns to IDLE, clears busy, and sets done=1 for exactly one cycle.
  - mode, shamt, data_in, start, and serial inputs are ignored.
- done is registered and otherwise 0. A new start is accepted in the same cycle done is high.
- clear_n assertion mid-burst aborts with no done.

Decomposition:
- Package iiitb_pusr_pkg holds the mode encodings (MODE_SHL..MODE_RSVD), FSM state typedef (IDLE, RUN), and width helper functions.
- One combinational sub-module, iiitb_pusr_shifter(value, op, shamt, sl_fill, sr_fill) -> next value, is shared by the direct and burst paths.
- Top level contains the register, FSM, and counter.

Test Plan:
- WIDTH=8: clear_n=0 -> data_out=00, busy=0, done=0. Release, LOAD data_in=AB en=1 -> AB. en=0 with LOAD data_in=FF -> stays AB.
- From AB: SHR shamt=1 sr_ser=1 -> D5. From AB: SHL shamt=3 sl_ser=0 -> 58. From AB: HOLD, and from AB: mode 111 -> AB.
- From AB: ROTL shamt=4 -> BA. Load 90, then ASR shamt=2 -> E4. From 90: ROTR shamt=0 -> 90.
- Load 81. start ROTR shamt=1 burst_len=3 -> sequence C0, 60, 30. busy high for 2 cycles. done pulses once, with data_out=30. Mode changes during RUN have no effect.
- Repeat the burst with en=0 for 2 cycles after op 1 -> busy extended by 2 cycles, final value 30. burst_len=1 -> C0, busy never high, done pulses.
- Mid-burst sync_clr=1 -> data_out=00, busy=0, no done. Mid-burst clear_n=0 (async, between edges) -> immediate 00, busy=0, no done.

Source files
------------

// File: rtl/iiitb_pusr_pkg.sv
// Shared definitions for the parametrised universal shift register:
// operation codes, burst FSM states and derived width helpers.
package iiitb_pusr_pkg;

    typedef enum logic [2:0] {
        MODE_SHL  = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_LOAD = 3'b010,
        MODE_HOLD = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int sh_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Only the movement operations can be repeated by the burst engine.
    function automatic logic is_burst_mode(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/iiitb_pusr_shifter.sv
// Combinational multi-position shift/rotate stage shared by direct and burst paths.
// LOAD/HOLD/reserved codes pass the value through; the top handles LOAD.
module iiitb_pusr_shifter
    import iiitb_pusr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SH_W = sh_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  mode_e            op,
    input  logic [SH_W-1:0]  shamt,
    input  logic             sl_fill,
    input  logic             sr_fill,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot;

    assign dbl = {value, value};

    always_comb begin
        result = value;
        rot    = '0;
        // Out-of-range amounts (non power-of-2 WIDTH only) leave the value untouched.
        if (int'(shamt) < WIDTH) begin
            case (op)
                MODE_SHL:  result = (value << shamt) | (sl_fill ? ~(ONES << shamt) : '0);
                MODE_SHR:  result = (value >> shamt) | (sr_fill ? ~(ONES >> shamt) : '0);
                MODE_ROTL: begin
                    rot    = dbl << shamt;
                    result = rot[2*WIDTH-1:WIDTH];
                end
                MODE_ROTR: begin
                    rot    = dbl >> shamt;
                    result = rot[WIDTH-1:0];
                end
                MODE_ASR:  result = $unsigned($signed(value) >>> shamt);
                default:   result = value;
            endcase
        end
    end

endmodule

// File: rtl/iiitb_pusr.sv
// Universal shift register with direct ops and a burst engine that repeats
// a latched shift/rotate for burst_len enabled cycles, reporting busy/done.
module iiitb_pusr
    import iiitb_pusr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SH_W  = sh_width(WIDTH),
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [SH_W-1:0]  shamt,
    input  logic             sl_ser,
    input  logic             sr_ser,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             sl_out,
    output logic             sr_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    mode_e            op_q, op_d;
    logic [SH_W-1:0]  shamt_q, shamt_d;
    logic             sl_q, sl_d;
    logic             sr_q, sr_d;

    mode_e            mode_in;
    mode_e            sh_op;
    logic [SH_W-1:0]  sh_amt;
    logic             sh_sl;
    logic             sh_sr;
    logic [WIDTH-1:0] sh_res;
    logic             accept;

    assign mode_in = mode_e'(mode);

    // During RUN the shifter sees the latched operation, otherwise the live inputs.
    assign sh_op  = (state_q == RUN) ? op_q    : mode_in;
    assign sh_amt = (state_q == RUN) ? shamt_q : shamt;
    assign sh_sl  = (state_q == RUN) ? sl_q    : sl_ser;
    assign sh_sr  = (state_q == RUN) ? sr_q    : sr_ser;

    iiitb_pusr_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value   (data_q),
        .op      (sh_op),
        .shamt   (sh_amt),
        .sl_fill (sh_sl),
        .sr_fill (sh_sr),
        .result  (sh_res)
    );

    assign accept = (state_q == IDLE) && en && start &&
                    (burst_len != '0) && is_burst_mode(mode_in);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        op_d    = op_q;
        shamt_d = shamt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        if (sync_clr) begin
            data_d  = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (en) begin
                data_d = sh_res;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (accept) begin
            // The accepting edge already performs the first operation.
            data_d  = sh_res;
            op_d    = mode_in;
            shamt_d = shamt;
            sl_d    = sl_ser;
            sr_d    = sr_ser;
            if (burst_len == CNT_W'(1)) begin
                done_d = 1'b1;
            end else begin
                state_d = RUN;
                cnt_d   = burst_len - CNT_W'(1);
            end
        end else if (en) begin
            data_d = (mode_in == MODE_LOAD) ? data_in : sh_res;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            op_q    <= MODE_HOLD;
            shamt_q <= '0;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
        end
    end

    assign data_out = data_q;
    assign sl_out   = data_q[WIDTH-1];
    assign sr_out   = data_q[0];
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_iiitb_pusr.sv
// Scoreboard bench for iiitb_pusr (WIDTH=8): stimulus queues expected
// post-edge state, a negedge monitor pops and compares.
module tb_iiitb_pusr;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             clear_n = 1'b1;
    logic             sync_clr = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'b011;
    logic [2:0]       shamt = '0;
    logic             sl_ser = 1'b0;
    logic             sr_ser = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             start = 1'b0;
    logic [3:0]       burst_len = '0;
    logic [WIDTH-1:0] data_out;
    logic             sl_out, sr_out, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       b;
        logic       dn;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    iiitb_pusr #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .sync_clr  (sync_clr),
        .en        (en),
        .mode      (mode),
        .shamt     (shamt),
        .sl_ser    (sl_ser),
        .sr_ser    (sr_ser),
        .data_in   (data_in),
        .start     (start),
        .burst_len (burst_len),
        .data_out  (data_out),
        .sl_out    (sl_out),
        .sr_out    (sr_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    function automatic void compare(input string nm, input logic [7:0] d,
                                    input logic b, input logic dn);
        checks++;
        if (data_out !== d || busy !== b || done !== dn ||
            sl_out !== d[7] || sr_out !== d[0]) begin
            failures++;
            $display("FAIL %s: got data=%h busy=%b done=%b sl=%b sr=%b, want data=%h busy=%b done=%b",
                     nm, data_out, busy, done, sl_out, sr_out, d, b, dn);
        end else begin
            $display("ok   %s: data=%h busy=%b done=%b", nm, data_out, busy, done);
        end
    endfunction

    // Monitor: one expectation per clock, compared away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                compare(e.nm, e.d, e.b, e.dn);
            end
        end
    end

    // Queue the expected state after the coming edge, then move to the next cycle.
    task automatic go(input string nm, input logic [7:0] d, input logic b, input logic dn);
        exp_t e;
        e.d = d; e.b = b; e.dn = dn; e.nm = nm;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
    endtask

    task automatic set_op(input logic [2:0] m, input int sh, input logic sl, input logic sr);
        mode = m; shamt = 3'(sh); sl_ser = sl; sr_ser = sr;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; start = 1'b0; mode = 3'b010; data_in = v;
        go("load", v, 1'b0, 1'b0);
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "timeout");
            end
        join_none

        #1 clear_n = 1'b0;
        #1 compare("async_reset", 8'h00, 1'b0, 1'b0);
        @(negedge clock); @(negedge clock); #1;
        clear_n = 1'b1;

        load(8'hAB);
        en = 1'b0; data_in = 8'hFF;
        go("en0_load_blocked", 8'hAB, 1'b0, 1'b0);
        en = 1'b1;

        set_op(3'b001, 1, 1'b0, 1'b1); go("shr1_fill1", 8'hD5, 1'b0, 1'b0);
        load(8'hAB);
        set_op(3'b000, 3, 1'b0, 1'b0); go("shl3_fill0", 8'h58, 1'b0, 1'b0);
        load(8'hAB);
        set_op(3'b011, 2, 1'b1, 1'b1); go("hold", 8'hAB, 1'b0, 1'b0);
        set_op(3'b111, 2, 1'b1, 1'b1); go("reserved_hold", 8'hAB, 1'b0, 1'b0);
        set_op(3'b100, 4, 1'b0, 1'b0); go("rotl4", 8'hBA, 1'b0, 1'b0);
        load(8'h90);
        set_op(3'b110, 2, 1'b0, 1'b0); go("asr2", 8'hE4, 1'b0, 1'b0);
        load(8'h90);
        set_op(3'b101, 0, 1'b0, 1'b0); go("rotr0", 8'h90, 1'b0, 1'b0);
        set_op(3'b000, 7, 1'b1, 1'b0); go("shl7_fill1", 8'h7F, 1'b0, 1'b0);

        // start with non-burst mode or zero length acts as a direct op
        start = 1'b1; burst_len = 4'd3; data_in = 8'h5A; set_op(3'b010, 1, 1'b0, 1'b0);
        go("start_load_ignored", 8'h5A, 1'b0, 1'b0);
        burst_len = 4'd0; set_op(3'b101, 1, 1'b0, 1'b0);
        go("start_len0_direct", 8'h2D, 1'b0, 1'b0);
        start = 1'b0;

        // Burst ROTR x3 from 81, with mode changes ignored during RUN
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; set_op(3'b101, 1, 1'b0, 1'b0);
        go("burst_op1", 8'hC0, 1'b1, 1'b0);
        start = 1'b0; set_op(3'b000, 3, 1'b1, 1'b1);
        go("burst_op2", 8'h60, 1'b1, 1'b0);
        go("burst_op3_done", 8'h30, 1'b0, 1'b1);
        set_op(3'b011, 0, 1'b0, 1'b0);
        go("burst_after", 8'h30, 1'b0, 1'b0);

        // Same burst stalled by en=0 for two cycles
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; set_op(3'b101, 1, 1'b0, 1'b0);
        go("stall_op1", 8'hC0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b0;
        go("stall_a", 8'hC0, 1'b1, 1'b0);
        go("stall_b", 8'hC0, 1'b1, 1'b0);
        en = 1'b1;
        go("stall_op2", 8'h60, 1'b1, 1'b0);
        go("stall_op3_done", 8'h30, 1'b0, 1'b1);
        set_op(3'b011, 0, 1'b0, 1'b0);
        go("stall_after", 8'h30, 1'b0, 1'b0);

        // Single-op burst
        load(8'h81);
        start = 1'b1; burst_len = 4'd1; set_op(3'b101, 1, 1'b0, 1'b0);
        go("len1_done", 8'hC0, 1'b0, 1'b1);
        start = 1'b0; set_op(3'b011, 0, 1'b0, 1'b0);
        go("len1_after", 8'hC0, 1'b0, 1'b0);

        // sync_clr mid-burst
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; set_op(3'b101, 1, 1'b0, 1'b0);
        go("sclr_op1", 8'hC0, 1'b1, 1'b0);
        start = 1'b0; sync_clr = 1'b1;
        go("sclr_abort", 8'h00, 1'b0, 1'b0);
        sync_clr = 1'b0; set_op(3'b011, 0, 1'b0, 1'b0);
        go("sclr_no_done", 8'h00, 1'b0, 1'b0);

        // clear_n mid-burst, between edges
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; set_op(3'b101, 1, 1'b0, 1'b0);
        go("areset_op1", 8'hC0, 1'b1, 1'b0);
        start = 1'b0;
        #2 clear_n = 1'b0;
        #1 compare("areset_immediate", 8'h00, 1'b0, 1'b0);
        @(negedge clock); #1;
        clear_n = 1'b1; set_op(3'b011, 0, 1'b0, 1'b0);
        go("areset_no_done", 8'h00, 1'b0, 1'b0);
        go("areset_idle", 8'h00, 1'b0, 1'b0);

        @(negedge clock); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
